// File: rtl/video_pkg.sv
// Shared types and constants for the video framebuffer swap controller.
package video_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_SYNC,
        S_COMMIT
    } state_t;

    localparam logic [3:0] COMMIT_ADDR = 4'b1000;

    typedef logic master_idx_t;

endpackage

// File: rtl/video_rr_arb.sv
// Two-way round-robin arbiter: on a tie the master not granted last wins;
// the last-grant record only moves when the granted transfer is taken.
module video_rr_arb
    import video_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_i,
    input  logic        advance_i,
    output logic [1:0]  grant_o,
    output master_idx_t last_o
);

    master_idx_t last_q, last_d;

    always_comb begin
        grant_o = req_i;
        if (req_i == 2'b11) begin
            grant_o = last_q ? 2'b01 : 2'b10;
        end
    end

    always_comb begin
        last_d = last_q;
        if (advance_i) begin
            last_d = grant_o[1];
        end
    end

    // m1 recorded as last so m0 wins the first tie after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    assign last_o = last_q;

endmodule

// File: rtl/video_swap_ctrl.sv
// Bus-side controller: arbitrates CPU/DMA writes onto the video port and defers
// commits to the next frame boundary. Optional forced commit: VIDEO_SWAP_TIMEOUT_EN.
module video_swap_ctrl
    import video_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int NUM_WORDS    = 8,
    parameter int SYNC_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_valid,
    output logic              m0_ready,
    input  logic [3:0]        m0_addr,
    input  logic [DATA_W-1:0] m0_data,
    input  logic              m1_valid,
    output logic              m1_ready,
    input  logic [3:0]        m1_addr,
    input  logic [DATA_W-1:0] m1_data,
    input  logic              frame_sync,
    output logic              vid_we,
    output logic [3:0]        vid_addr,
    output logic [DATA_W-1:0] vid_data,
    output logic              busy,
    output logic [7:0]        commit_cnt,
    output logic              timeout_flag
);

    localparam int AW = $clog2(NUM_WORDS);

    state_t            state_q, state_d;
    logic              vid_we_q, vid_we_d;
    logic [3:0]        vid_addr_q, vid_addr_d;
    logic [DATA_W-1:0] vid_data_q, vid_data_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [1:0]        grant;
    master_idx_t       last_grant;
    logic              xfer;
    logic              tmo_hit;
    logic [3:0]        sel_addr;
    logic [DATA_W-1:0] sel_data;

    video_rr_arb u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    ({m1_valid, m0_valid}),
        .advance_i(xfer),
        .grant_o  (grant),
        .last_o   (last_grant)
    );

    assign m0_ready = (state_q == S_IDLE) && grant[0];
    assign m1_ready = (state_q == S_IDLE) && grant[1];
    assign xfer     = (m0_valid && m0_ready) || (m1_valid && m1_ready);
    assign sel_addr = grant[1] ? m1_addr : m0_addr;
    assign sel_data = grant[1] ? m1_data : m0_data;

`ifdef VIDEO_SWAP_TIMEOUT_EN
    localparam int TMO_W = (SYNC_TIMEOUT > 1) ? $clog2(SYNC_TIMEOUT) : 1;

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             flag_q, flag_d;

    assign tmo_hit = (tmo_q == TMO_W'(SYNC_TIMEOUT - 1));

    // Counter is held at zero outside WAIT_SYNC, so it starts cleared on entry
    always_comb begin
        tmo_d  = '0;
        flag_d = flag_q;
        if (state_q == S_WAIT_SYNC) begin
            tmo_d = tmo_q + 1'b1;
            if (tmo_hit && !frame_sync) begin
                flag_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            tmo_q  <= tmo_d;
            flag_q <= flag_d;
        end
    end

    assign timeout_flag = flag_q;
`else
    assign tmo_hit      = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        vid_we_d   = 1'b0;
        vid_addr_d = vid_addr_q;
        vid_data_d = vid_data_q;
        cnt_d      = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    if (sel_addr[3]) begin
                        state_d = S_WAIT_SYNC;
                    end else begin
                        vid_we_d   = 1'b1;
                        vid_addr_d = 4'(sel_addr[AW-1:0]);
                        vid_data_d = sel_data;
                    end
                end
            end
            S_WAIT_SYNC: begin
                if (frame_sync || tmo_hit) begin
                    state_d    = S_COMMIT;
                    vid_we_d   = 1'b1;
                    vid_addr_d = COMMIT_ADDR;
                    vid_data_d = '0;
                    cnt_d      = cnt_q + 8'd1;
                end
            end
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            vid_we_q   <= 1'b0;
            vid_addr_q <= '0;
            vid_data_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            vid_we_q   <= vid_we_d;
            vid_addr_q <= vid_addr_d;
            vid_data_q <= vid_data_d;
            cnt_q      <= cnt_d;
        end
    end

    assign vid_we     = vid_we_q;
    assign vid_addr   = vid_addr_q;
    assign vid_data   = vid_data_q;
    assign busy       = (state_q != S_IDLE);
    assign commit_cnt = cnt_q;

endmodule

// File: tb/tb_video_swap_ctrl.sv
// Self-checking bench for video_swap_ctrl: vector table plus hand sequences,
// with a reference model feeding a scoreboard of expected video-port writes.
module tb_video_swap_ctrl;

    localparam int TB_TMO = 16;

    typedef struct {
        logic        m0v;
        logic [3:0]  m0a;
        logic [31:0] m0d;
        logic        m1v;
        logic [3:0]  m1a;
        logic [31:0] m1d;
        logic        sync;
        logic        er0;
        logic        er1;
    } vec_t;

    typedef struct {
        logic [3:0]  a;
        logic [31:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_valid = 1'b0, m1_valid = 1'b0, frame_sync = 1'b0;
    logic [3:0]  m0_addr = '0, m1_addr = '0;
    logic [31:0] m0_data = '0, m1_data = '0;
    logic        m0_ready, m1_ready, vid_we, busy, timeout_flag;
    logic [3:0]  vid_addr;
    logic [31:0] vid_data;
    logic [7:0]  commit_cnt;

    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];
    int   m_state = 0;
    int   m_tmo = 0;
    logic [7:0] m_cnt = '0;
    logic m_flag = 1'b0;

    video_swap_ctrl #(.DATA_W(32), .NUM_WORDS(8), .SYNC_TIMEOUT(TB_TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr), .m0_data(m0_data),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr), .m1_data(m1_data),
        .frame_sync(frame_sync), .vid_we(vid_we), .vid_addr(vid_addr), .vid_data(vid_data),
        .busy(busy), .commit_cnt(commit_cnt), .timeout_flag(timeout_flag)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic m0v, input logic [3:0] m0a, input logic [31:0] m0d,
                                input logic m1v, input logic [3:0] m1a, input logic [31:0] m1d,
                                input logic sync, input logic er0, input logic er1);
        vec_t v;
        v.m0v = m0v; v.m0a = m0a; v.m0d = m0d;
        v.m1v = m1v; v.m1a = m1a; v.m1d = m1d;
        v.sync = sync; v.er0 = er0; v.er1 = er1;
        return v;
    endfunction

    task automatic model_commit();
        exp_t e;
        e.a = 4'h8;
        e.d = 32'h0;
        sb.push_back(e);
        m_cnt++;
        m_state = 2;
    endtask

    task automatic model_accept(input logic [3:0] a, input logic [31:0] d);
        exp_t e;
        if (a[3]) begin
            m_state = 1;
            m_tmo = 0;
        end else begin
            e.a = {1'b0, a[2:0]};
            e.d = d;
            sb.push_back(e);
        end
    endtask

    task automatic model_step(input vec_t v);
        case (m_state)
            0: begin
                if (v.er0 && v.m0v) model_accept(v.m0a, v.m0d);
                else if (v.er1 && v.m1v) model_accept(v.m1a, v.m1d);
            end
            1: begin
                if (v.sync) begin
                    model_commit();
                end else begin
`ifdef VIDEO_SWAP_TIMEOUT_EN
                    if (m_tmo == TB_TMO - 1) begin
                        model_commit();
                        m_flag = 1'b1;
                    end else begin
                        m_tmo++;
                    end
`endif
                end
            end
            default: m_state = 0;
        endcase
    endtask

    task automatic check_outputs(input string nm);
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({nm, ".vid_we"}, 32'(vid_we), 32'd1);
            chk({nm, ".vid_addr"}, 32'(vid_addr), 32'(e.a));
            chk({nm, ".vid_data"}, vid_data, e.d);
        end else begin
            chk({nm, ".vid_we_idle"}, 32'(vid_we), 32'd0);
        end
        chk({nm, ".busy"}, 32'(busy), 32'(m_state != 0));
        chk({nm, ".commit_cnt"}, 32'(commit_cnt), 32'(m_cnt));
        chk({nm, ".timeout_flag"}, 32'(timeout_flag), 32'(m_flag));
    endtask

    task automatic do_cycle(input vec_t v, input string nm);
        @(negedge clk);
        m0_valid = v.m0v; m0_addr = v.m0a; m0_data = v.m0d;
        m1_valid = v.m1v; m1_addr = v.m1a; m1_data = v.m1d;
        frame_sync = v.sync;
        #1;
        chk({nm, ".m0_ready"}, 32'(m0_ready), 32'(v.er0));
        chk({nm, ".m1_ready"}, 32'(m1_ready), 32'(v.er1));
        model_step(v);
        @(posedge clk);
        #1;
        check_outputs(nm);
    endtask

    task automatic idle_cycle(input string nm, input logic sync);
        do_cycle(mk(0, 4'h0, 32'h0, 0, 4'h0, 32'h0, sync, 0, 0), nm);
    endtask

    initial begin
        vec_t tbl[12];

        // Tie arbitration from reset (m0 first), then lone masters
        tbl[0]  = mk(1, 4'h0, 32'hA000_0000, 1, 4'h4, 32'hB000_0000, 0, 1, 0);
        tbl[1]  = mk(1, 4'h1, 32'hA000_0001, 1, 4'h4, 32'hB000_0000, 0, 0, 1);
        tbl[2]  = mk(1, 4'h1, 32'hA000_0001, 1, 4'h5, 32'hB000_0001, 0, 1, 0);
        tbl[3]  = mk(1, 4'h2, 32'hA000_0002, 1, 4'h5, 32'hB000_0001, 0, 0, 1);
        tbl[4]  = mk(1, 4'h2, 32'hA000_0002, 1, 4'h6, 32'hB000_0002, 0, 1, 0);
        tbl[5]  = mk(1, 4'h3, 32'hA000_0003, 1, 4'h6, 32'hB000_0002, 0, 0, 1);
        tbl[6]  = mk(1, 4'h3, 32'hA000_0003, 1, 4'h7, 32'hB000_0003, 0, 1, 0);
        tbl[7]  = mk(0, 4'h0, 32'h0,         1, 4'h7, 32'hB000_0003, 0, 0, 1);
        tbl[8]  = mk(1, 4'h3, 32'hDEAD_BEEF, 0, 4'h0, 32'h0,         0, 1, 0);
        tbl[9]  = mk(0, 4'h0, 32'h0,         0, 4'h0, 32'h0,         0, 0, 0);
        tbl[10] = mk(0, 4'h0, 32'h0,         1, 4'h2, 32'h1234_5678, 0, 0, 1);
        tbl[11] = mk(0, 4'h0, 32'h0,         0, 4'h0, 32'h0,         1, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("rst.vid_we", 32'(vid_we), 32'd0);
        chk("rst.vid_addr", 32'(vid_addr), 32'd0);
        chk("rst.vid_data", vid_data, 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.commit_cnt", 32'(commit_cnt), 32'd0);
        chk("rst.timeout_flag", 32'(timeout_flag), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            do_cycle(tbl[i], $sformatf("tbl%0d", i));
        end

        // Commit from m1, sync five cycles later; m0 waits with a write
        do_cycle(mk(0, 4'h0, 32'h0, 1, 4'h8, 32'hFFFF_FFFF, 0, 0, 1), "t3.accept");
        for (int i = 0; i < 4; i++) begin
            do_cycle(mk(1, 4'h1, 32'h0000_1111, 0, 4'h0, 32'h0, 0, 0, 0), "t3.wait");
        end
        do_cycle(mk(1, 4'h1, 32'h0000_1111, 0, 4'h0, 32'h0, 1, 0, 0), "t3.sync");
        do_cycle(mk(1, 4'h1, 32'h0000_1111, 0, 4'h0, 32'h0, 0, 0, 0), "t3.commit");
        do_cycle(mk(1, 4'h1, 32'h0000_1111, 0, 4'h0, 32'h0, 0, 1, 0), "t3.idle");
        idle_cycle("t3.tail", 1'b0);

        // Sync coinciding with commit acceptance must not fire the commit
        do_cycle(mk(1, 4'h8, 32'h0, 0, 4'h0, 32'h0, 1, 1, 0), "t4.accept");
        for (int i = 0; i < 3; i++) idle_cycle("t4.wait", 1'b0);
        idle_cycle("t4.sync", 1'b1);
        idle_cycle("t4.commit", 1'b0);
        idle_cycle("t4.idle", 1'b0);

        // Reset while a commit is pending
        do_cycle(mk(0, 4'h0, 32'h0, 1, 4'h8, 32'h0, 0, 0, 1), "t5.accept");
        idle_cycle("t5.wait", 1'b0);
        idle_cycle("t5.wait", 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t5.rst.vid_we", 32'(vid_we), 32'd0);
        chk("t5.rst.busy", 32'(busy), 32'd0);
        chk("t5.rst.commit_cnt", 32'(commit_cnt), 32'd0);
        sb.delete();
        m_state = 0;
        m_cnt = '0;
        m_flag = 1'b0;
        @(posedge clk);
        #1;
        chk("t5.rst_hold.vid_we", 32'(vid_we), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_cycle(mk(0, 4'h0, 32'h0, 1, 4'h5, 32'hCAFE_F00D, 0, 0, 1), "t5.write");
        idle_cycle("t5.tail", 1'b0);

        // Commit with no frame sync: forced after the timeout, or held forever
        do_cycle(mk(1, 4'h8, 32'h0, 0, 4'h0, 32'h0, 0, 1, 0), "t6.accept");
        for (int i = 0; i < 20; i++) idle_cycle($sformatf("t6.c%0d", i), 1'b0);
        idle_cycle("t6.sync", 1'b1);
        idle_cycle("t6.after", 1'b0);
        idle_cycle("t6.after", 1'b0);
        do_cycle(mk(1, 4'h6, 32'h5555_AAAA, 0, 4'h0, 32'h0, 0, 1, 0), "t6.write");
        idle_cycle("t6.tail", 1'b0);

        chk("sb.empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
